// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Stall/bubble controller for the in-order 5-stage pipeline. Each architectural
// register has a small countdown that is loaded when a producer issues from ID
// and ticks down once per advancing cycle. A nonzero count means the register's
// value is not yet forwardable to ID, so a consumer in ID must wait. Memory
// waits hold the whole pipeline. A taken branch or jump squashes the younger
// instructions instead of stalling them.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   ID_valid                 ID holds a real instruction
//   ID_rX / ID_rX_used       source X index and read enable
//   ID_rY / ID_rY_used       source Y index and read enable
//   ID_wr_en / ID_rO         destination write enable and index
//   ID_is_load               instruction is a memory read
//   mem_busy                 data memory not done; whole pipeline holds
//   flush                    EX resolved a taken branch/jump
//   freeze_pc                hold PC
//   freeze_if2id             hold IF/ID register
//   freeze_id2ex             hold ID/EX register (memory wait)
//   bubble_id2ex             load NOP into ID/EX
//   squash_if2id             load NOP into IF/ID
//   issue                    ID instruction advances to EX this cycle
//
// Optional build macro HAZARD_PERF_EN adds:
//   perf_raw_stalls[31:0]    cycles lost to data hazards
//   perf_mem_waits[31:0]     cycles spent waiting on data memory
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NREGS    = 8,
    parameter int REG_W    = 3,
    parameter int ALU_LAT  = 0,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_valid,
    input  logic [REG_W-1:0] ID_rX,
    input  logic             ID_rX_used,
    input  logic [REG_W-1:0] ID_rY,
    input  logic             ID_rY_used,
    input  logic             ID_wr_en,
    input  logic [REG_W-1:0] ID_rO,
    input  logic             ID_is_load,
    input  logic             mem_busy,
    input  logic             flush,
    output logic             freeze_pc,
    output logic             freeze_if2id,
    output logic             freeze_id2ex,
    output logic             bubble_id2ex,
    output logic             squash_if2id,
    output logic             issue
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      perf_raw_stalls,
    output logic [31:0]      perf_mem_waits
`endif
);

    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] ALU_CNT  = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt [NREGS];
    logic             dep_x;
    logic             dep_y;
    logic             raw;

    // Indices are matched against every implemented entry rather than used
    // as an array subscript, so an index >= NREGS matches nothing and reads
    // as "ready" without any out-of-range access. The compare sees the
    // pre-update counts, so an instruction never stalls on its own write.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first;
        // a path that leaves one unassigned would infer a latch.
        dep_x = 1'b0;
        dep_y = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            if (ID_rX_used && ID_rX == REG_W'(r) && cnt[r] != '0) dep_x = 1'b1;
            if (ID_rY_used && ID_rY == REG_W'(r) && cnt[r] != '0) dep_y = 1'b1;
        end
        raw = ID_valid && (dep_x || dep_y);
    end

    // Priority: memory wait > flush > data hazard > normal issue.
    always_comb begin
        freeze_pc    = 1'b0;
        freeze_if2id = 1'b0;
        freeze_id2ex = 1'b0;
        bubble_id2ex = 1'b0;
        squash_if2id = 1'b0;
        issue        = 1'b0;
        if (mem_busy) begin
            freeze_pc    = 1'b1;
            freeze_if2id = 1'b1;
            freeze_id2ex = 1'b1;
        end else if (flush) begin
            // The PC is not frozen: it loads the redirect target.
            squash_if2id = 1'b1;
            bubble_id2ex = 1'b1;
        end else if (raw) begin
            freeze_pc    = 1'b1;
            freeze_if2id = 1'b1;
            bubble_id2ex = 1'b1;
        end else begin
            issue = ID_valid;
        end
    end

    // The counts only advance while the pipeline moves. A newly issued write
    // replaces whatever count its destination held, even a larger one: the
    // pipeline is in order, so the newest producer is the one consumers see.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // entry updates from the same pre-edge values.
        if (rst) begin
            // NOTE: the count array is reset (not left uninitialised like a
            // data RAM) because stale counts would stall issue after reset.
            for (int r = 0; r < NREGS; r++) cnt[r] <= '0;
        end else if (!mem_busy) begin
            for (int r = 0; r < NREGS; r++) begin
                if (issue && ID_wr_en && ID_rO == REG_W'(r)) begin
                    cnt[r] <= ID_is_load ? LOAD_CNT : ALU_CNT;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CNT_ONE;
                end
            end
        end
    end

`ifdef HAZARD_PERF_EN
    // Free-running event counters; they wrap naturally at 2**32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_raw_stalls <= '0;
            perf_mem_waits  <= '0;
        end else begin
            if (raw && !mem_busy && !flush) perf_raw_stalls <= perf_raw_stalls + 32'd1;
            if (mem_busy)                   perf_mem_waits  <= perf_mem_waits + 32'd1;
        end
    end
`endif

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised stall/bubble controller for the in-order 5-stage pipeline.
- Replaces the single-cycle load-use compare with a per-register countdown scoreboard, so load and ALU result latencies are configurable.
- Adds a variable-latency data-memory wait (cache miss) and branch/jump flush priority.
- Sits beside the ID stage; drives the PC and the IF/ID and ID/EX pipeline-register controls.

Parameters:
- NREGS, 8, number of architectural registers.
- REG_W, 3, register index width; NREGS <= 2**REG_W.
- ALU_LAT, 0, cycles after issue before an ALU result is forwardable to ID.
- LOAD_LAT, 1, cycles after issue before a load result is forwardable to ID.
- CNT_W, 2, scoreboard counter width; must hold max(ALU_LAT, LOAD_LAT).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- ID_valid  in  1  ID holds a real instruction.
- ID_rX  in  REG_W  source X index.
- ID_rX_used  in  1  instruction reads rX.
- ID_rY  in  REG_W  source Y index.
- ID_rY_used  in  1  instruction reads rY.
- ID_wr_en  in  1  instruction writes a register.
- ID_rO  in  REG_W  destination index.
- ID_is_load  in  1  instruction is a memory read.
- mem_busy  in  1  data memory not done; whole pipeline holds.
- flush  in  1  EX resolved a taken branch or jump; squash IF/ID.
- freeze_pc  out  1  hold PC.
- freeze_if2id  out  1  hold IF/ID register.
- freeze_id2ex  out  1  hold ID/EX register (memory wait).
- bubble_id2ex  out  1  load NOP into ID/EX.
- squash_if2id  out  1  load NOP into IF/ID.
- issue  out  1  ID instruction advances to EX this cycle.

Behaviour:
- State: cnt[0..NREGS-1], each CNT_W bits. cnt[r]==0 means r is forwardable or in the register file.
- Reset (async, any time, including mid-stall or mid-wait): all cnt cleared to 0.
  - Combinational outputs reflect the cleared scoreboard immediately.
  - With ID_valid=0, mem_busy=0 and flush=0, every output is 0.
- Combinational hazard:
  - depX = ID_rX_used && cnt[ID_rX]!=0; depY likewise.
  - raw = ID_valid && (depX || depY).
- Output priority (mem_busy > flush > raw):
  - mem_busy=1: freeze_pc = freeze_if2id = freeze_id2ex = 1; bubble, squash and issue = 0; scoreboard holds unchanged.
  - flush=1 (mem_busy=0): squash_if2id=1, bubble_id2ex=1, freeze_* = 0, issue=0. The PC loads the redirect target.
  - raw=1: freeze_pc=1, freeze_if2id=1, bubble_id2ex=1, freeze_id2ex=0, issue=0.
  - Otherwise: issue=ID_valid; all others 0.
- Scoreboard update (when mem_busy=0):
  - Every nonzero cnt decrements by 1, saturating at 0.
  - If issue && ID_wr_en: cnt[ID_rO] <= (ID_is_load ? LOAD_LAT : ALU_LAT). This overrides the decrement for that entry.
  - WAW: the newer write overwrites the old count even if the new count is smaller (in-order pipeline, newer value is the one consumed).
- Self-dependency (rO == rX, issued this cycle) does not stall its own issue; the compare uses pre-update cnt.
- Index >= NREGS: treated as cnt==0; never written.
- Timing, LOAD_LAT=1:
  - Load issues at cycle t.
  - A dependent instruction in ID at t+1 stalls one cycle.
  - It issues at t+2, matching the classic load-use single bubble.
- ALU_LAT=0: ALU producers never cause stalls.

Optional Feature:
- HAZARD_PERF_EN defined: adds outputs perf_raw_stalls[31:0] and perf_mem_waits[31:0].
  - perf_raw_stalls increments on cycles with raw=1, mem_busy=0 and flush=0.
  - perf_mem_waits increments on cycles with mem_busy=1.
  - Both wrap at 2**32; both async-clear on rst.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Load-use, defaults: issue load rO=3, then ID rX=3 used -> stall 1 cycle (freeze_pc=1, bubble=1), issue on the 2nd cycle; cnt[3]=1 then 0.
- ALU chain, ALU_LAT=0: back-to-back writes/reads of r2 -> issue=1 every cycle, no bubbles.
- LOAD_LAT=3 build: load r5, dependent on rY=5 next -> exactly 3 stall cycles, issue on the 4th.
- mem_busy held 4 cycles during a pending load stall -> freeze_id2ex=1, bubble=0, cnt frozen at its value; stall resumes afterward with the same remaining count.
- flush with raw active -> squash_if2id=1, bubble=1, freeze_pc=0; flush with mem_busy -> freezes only, squash=0.
- Async rst asserted mid-stall with cnt[4]=1 -> cnt cleared, raw=0 immediately; under HAZARD_PERF_EN both perf counters read 0.
